// File: rtl/auth_msg_receiver.sv
// Far-end receiver for the authentication message stream: captures a packed
// message, unpacks and checks it, hands it to a sink, then acks the sender.
module auth_msg_receiver #(
  parameter int          MSG_LEN     = 160,
  parameter int          PAY_W       = 96,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [7:0]  PROTO_VER   = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MSG_LEN-1:0] auth_msg_in,
  input  logic               auth_msg_ready,
  input  logic               usb_framed,
  output logic               Ack_out,
  output logic               msg_valid,
  input  logic               msg_accept,
  output logic [7:0]         bmRequestType,
  output logic [7:0]         bRequest,
  output logic [15:0]        wLength,
  output logic [31:0]        header,
  output logic [PAY_W-1:0]   payload,
  output logic               err_version,
  output logic               err_type,
  output logic               err_length,
  output logic               err_timeout,
  output logic               busy
);
  localparam logic [15:0] LEN_MAX = 16'(4 + PAY_W/8);
  localparam logic [15:0] T_LAST  = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, CHECK, DELIVER, ACK, WAIT_DROP} state_t;
  state_t state, state_nx;

  logic        framed;
  logic [15:0] timer;
  logic        bad_ver, bad_type, bad_len, any_bad, capture, expire;

  always_comb begin
    bad_ver  = header[31:24] != PROTO_VER;
    bad_type = !(header[23:16] inside {8'h01, 8'h02, 8'h03, 8'h7F, 8'h81, 8'h82, 8'h83});
    bad_len  = framed && ((wLength < 16'd4) || (wLength > LEN_MAX) ||
                          !(bRequest inside {8'h18, 8'h19}) ||
                          !(bmRequestType inside {8'h01, 8'h81}));
  end

  assign any_bad = bad_ver | bad_type | bad_len;
  assign capture = (state == IDLE) && auth_msg_ready;
  // an accept on the final timer cycle wins over the timeout
  assign expire  = (state == DELIVER) && !msg_accept && (timer == T_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (auth_msg_ready) state_nx = CHECK;
      CHECK:     state_nx = any_bad ? ACK : DELIVER;
      DELIVER:   if (msg_accept || expire) state_nx = ACK;
      ACK:       state_nx = WAIT_DROP;
      WAIT_DROP: if (!auth_msg_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      framed        <= 1'b0;
      bmRequestType <= '0;
      bRequest      <= '0;
      wLength       <= '0;
      header        <= '0;
      payload       <= '0;
    end else if (capture) begin
      framed        <= usb_framed;
      bmRequestType <= usb_framed ? auth_msg_in[MSG_LEN-1 -: 8]  : 8'h00;
      bRequest      <= usb_framed ? auth_msg_in[MSG_LEN-9 -: 8]  : 8'h00;
      wLength       <= usb_framed ? auth_msg_in[PAY_W+15 -: 16] : 16'h0000;
      header        <= usb_framed ? auth_msg_in[MSG_LEN-17 -: 32] : auth_msg_in[PAY_W+31 -: 32];
      payload       <= auth_msg_in[PAY_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_version <= 1'b0;
      err_type    <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
    end else if (capture) begin
      err_version <= 1'b0;
      err_type    <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
    end else if (state == CHECK) begin
      err_version <= bad_ver;
      err_type    <= bad_type;
      err_length  <= bad_len;
    end else if (expire) begin
      err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset)                 timer <= '0;
    else if (state == CHECK)    timer <= '0;
    else if (state == DELIVER)  timer <= timer + 16'd1;

  assign msg_valid = (state == DELIVER);
  assign Ack_out   = (state == ACK);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_auth_msg_receiver.sv
// Directed bench for auth_msg_receiver: a procedural transaction model predicts
// every output each cycle; literal expectations pin timing and decoded fields.
module tb_auth_msg_receiver;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [159:0] auth_msg_in = '0;
  logic         auth_msg_ready = 1'b0, usb_framed = 1'b0, msg_accept = 1'b0;
  logic         Ack_out, msg_valid, busy;
  logic [7:0]   bmRequestType, bRequest;
  logic [15:0]  wLength;
  logic [31:0]  header;
  logic [95:0]  payload;
  logic         err_version, err_type, err_length, err_timeout;

  auth_msg_receiver #(.MSG_LEN(160), .PAY_W(96), .TIMEOUT_CYC(TO), .PROTO_VER(8'h01)) dut (
    .clk(clk), .reset(reset), .auth_msg_in(auth_msg_in), .auth_msg_ready(auth_msg_ready),
    .usb_framed(usb_framed), .Ack_out(Ack_out), .msg_valid(msg_valid), .msg_accept(msg_accept),
    .bmRequestType(bmRequestType), .bRequest(bRequest), .wLength(wLength), .header(header),
    .payload(payload), .err_version(err_version), .err_type(err_type), .err_length(err_length),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // model expectations
  logic [7:0]  e_bm, e_br;
  logic [15:0] e_wl;
  logic [31:0] e_hd;
  logic [95:0] e_pl;
  logic        e_ev, e_et, e_el, e_eto, e_valid, e_ack, e_busy;

  task automatic zero_exp();
    e_bm = '0; e_br = '0; e_wl = '0; e_hd = '0; e_pl = '0;
    e_ev = 0; e_et = 0; e_el = 0; e_eto = 0; e_valid = 0; e_ack = 0; e_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk or negedge reset);
  endtask

  // one message, from the capture edge to the return to idle
  task automatic handle_msg();
    logic ev, et, el, acc;
    if (usb_framed) begin
      e_bm = auth_msg_in[159:152]; e_br = auth_msg_in[151:144];
      e_hd = auth_msg_in[143:112]; e_wl = auth_msg_in[111:96];
    end else begin
      e_bm = '0; e_br = '0; e_wl = '0; e_hd = auth_msg_in[127:96];
    end
    e_pl = auth_msg_in[95:0];
    ev = e_hd[31:24] != 8'h01;
    et = !(e_hd[23:16] inside {8'h01, 8'h02, 8'h03, 8'h7F, 8'h81, 8'h82, 8'h83});
    el = usb_framed && (e_wl < 16'd4 || e_wl > 16'd16 ||
                        !(e_br inside {8'h18, 8'h19}) || !(e_bm inside {8'h01, 8'h81}));
    e_ev = 0; e_et = 0; e_el = 0; e_eto = 0; e_busy = 1;
    tick(); if (!reset) return;
    e_ev = ev; e_et = et; e_el = el;
    if (!(ev || et || el)) begin
      e_valid = 1; acc = 0;
      for (int n = 0; n < TO; n++) begin
        tick(); if (!reset) return;
        if (msg_accept) begin acc = 1; break; end
      end
      e_valid = 0;
      if (!acc) e_eto = 1;
    end
    e_ack = 1;
    tick(); if (!reset) return;
    e_ack = 0;
    do begin tick(); if (!reset) return; end while (auth_msg_ready);
    e_busy = 0;
  endtask

  initial begin : model
    zero_exp();
    forever begin
      tick();
      if (!reset) zero_exp();
      else if (auth_msg_ready) begin
        handle_msg();
        if (!reset) zero_exp();
      end
    end
  end

  int checks = 0, errors = 0;
  int n_cyc = 0;
  logic [63:0] vh = '0, ah = '0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("bmRequestType", 160'(bmRequestType), 160'(e_bm));
    chk("bRequest", 160'(bRequest), 160'(e_br));
    chk("wLength", 160'(wLength), 160'(e_wl));
    chk("header", 160'(header), 160'(e_hd));
    chk("payload", 160'(payload), 160'(e_pl));
    chk("err_version", 160'(err_version), 160'(e_ev));
    chk("err_type", 160'(err_type), 160'(e_et));
    chk("err_length", 160'(err_length), 160'(e_el));
    chk("err_timeout", 160'(err_timeout), 160'(e_eto));
    chk("msg_valid", 160'(msg_valid), 160'(e_valid));
    chk("Ack_out", 160'(Ack_out), 160'(e_ack));
    chk("busy", 160'(busy), 160'(e_busy));
    if (n_cyc < 64) begin vh[n_cyc] = msg_valid; ah[n_cyc] = Ack_out; end
    n_cyc++;
    @(posedge clk); #2;
  endtask

  task automatic run(input int k);
    repeat (k) cyc();
  endtask

  task automatic send(input logic [159:0] m, input logic f, input logic acc);
    auth_msg_in = m; usb_framed = f; msg_accept = acc; auth_msg_ready = 1;
    n_cyc = 0; vh = '0; ah = '0;
  endtask

  task automatic drop();
    auth_msg_ready = 0;
    run(3);
  endtask

  logic [159:0] m_usb, m_raw, m_ver, m_len, m_req, m_min, m_bad;

  initial begin
    m_usb = {8'h81, 8'h19, 32'h0183_0000, 16'h0010, 96'h0123_4567_89AB_CDEF_0011_2233};
    m_raw = {32'hDEAD_BEEF, 32'h0101_0200, {12{8'hA5}}};
    m_ver = {32'h0, 32'h0201_0000, 96'h1234};
    m_len = {8'h01, 8'h18, 32'h0101_0000, 16'h0020, 96'h5};
    m_req = {8'h81, 8'h20, 32'h0102_0000, 16'h0008, 96'h6};
    m_min = {8'h01, 8'h19, 32'h017F_0000, 16'h0004, 96'h7};
    m_bad = {8'h01, 8'h19, 32'h0105_0000, 16'h0003, 96'h8};

    run(2);
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_header", 160'(header), 160'(0));
    reset = 1;
    run(2);

    // USB frame, sink always ready
    send(m_usb, 1, 1); run(6);
    chk("usb_valid_c1", 160'(vh[1]), 160'(0));
    chk("usb_valid_c2", 160'(vh[2]), 160'(1));
    chk("usb_ack_c3", 160'(ah[3]), 160'(1));
    chk("usb_acks", 160'($countones(ah)), 160'(1));
    chk("usb_header", 160'(header), 160'(32'h0183_0000));
    chk("usb_wlength", 160'(wLength), 160'(16'h0010));
    chk("usb_bmreq", 160'(bmRequestType), 160'(8'h81));
    drop();
    chk("usb_idle", 160'(busy), 160'(0));

    // header+payload only
    send(m_raw, 0, 1); run(6);
    chk("raw_bmreq", 160'(bmRequestType), 160'(0));
    chk("raw_wlength", 160'(wLength), 160'(0));
    chk("raw_header", 160'(header), 160'(32'h0101_0200));
    chk("raw_payload", 160'(payload), 160'({12{8'hA5}}));
    chk("raw_acks", 160'($countones(ah)), 160'(1));
    drop();

    // bad version, then a legal frame clears the flag
    send(m_ver, 0, 1); run(6);
    chk("ver_err", 160'(err_version), 160'(1));
    chk("ver_nodeliver", 160'(vh), 160'(0));
    chk("ver_ack_c2", 160'(ah[2]), 160'(1));
    drop();
    send(m_raw, 0, 1); run(6);
    chk("ver_cleared", 160'(err_version), 160'(0));
    drop();

    // length / request checks
    send(m_len, 1, 1); run(6);
    chk("len_err", 160'(err_length), 160'(1));
    chk("len_nodeliver", 160'(vh), 160'(0));
    drop();
    send(m_req, 1, 1); run(6);
    chk("req_err", 160'(err_length), 160'(1));
    chk("req_nodeliver", 160'(vh), 160'(0));
    drop();
    send(m_min, 1, 1); run(6);
    chk("min_len_ok", 160'(err_length), 160'(0));
    chk("min_delivered", 160'(vh[2]), 160'(1));
    drop();
    send(m_bad, 1, 1); run(6);
    chk("multi_len", 160'(err_length), 160'(1));
    chk("multi_type", 160'(err_type), 160'(1));
    drop();

    // sink never ready: timeout, then held ready must not recapture
    send(m_usb, 1, 0); run(30);
    chk("to_valid_cycles", 160'($countones(vh)), 160'(TO));
    chk("to_err", 160'(err_timeout), 160'(1));
    chk("to_ack_c18", 160'(ah[18]), 160'(1));
    chk("to_acks", 160'($countones(ah)), 160'(1));
    chk("to_wait_drop", 160'(busy), 160'(1));
    drop();

    // accept on the final timer cycle
    send(m_usb, 1, 0); run(17);
    msg_accept = 1; run(5);
    chk("last_valid_cycles", 160'($countones(vh)), 160'(TO));
    chk("last_no_timeout", 160'(err_timeout), 160'(0));
    chk("last_ack_c18", 160'(ah[18]), 160'(1));
    drop();

    // reset during delivery
    send(m_usb, 1, 0); run(5);
    reset = 0; #1;
    chk("arst_valid", 160'(msg_valid), 160'(0));
    chk("arst_busy", 160'(busy), 160'(0));
    chk("arst_header", 160'(header), 160'(0));
    chk("arst_payload", 160'(payload), 160'(0));
    auth_msg_ready = 0; n_cyc = 0; ah = '0;
    run(3);
    chk("arst_no_ack", 160'(ah), 160'(0));
    reset = 1; run(1);
    send(m_usb, 1, 1); run(6);
    chk("post_valid_c2", 160'(vh[2]), 160'(1));
    chk("post_ack_c3", 160'(ah[3]), 160'(1));
    chk("post_header", 160'(header), 160'(32'h0183_0000));
    drop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
